// File: rtl/decode_pkg.sv
// Purpose: shared types for the decode-stage control slice (op classes, ALU codes, sequencer states, E controls).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decode_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_ORR = 3'd3,
    ALU_MUL = 3'd4,
    ALU_AVG = 3'd5,
    ALU_THR = 3'd6,
    ALU_SHL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_VEC  = 2'd1,
    SEQ_HALT = 2'd2
  } seq_state_e;

  // Everything that crosses the D->E boundary apart from lane bookkeeping.
  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       pc_src;
    alu_op_e    alu_ctl;
    logic [1:0] flag_write;
    logic       illegal;
  } ctrl_s;

  // Only the arithmetic ops produce meaningful C/V flags.
  function automatic logic writes_cv(input alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/decode_main_dec.sv
// Purpose: combinational Op/Funct/Rd decode into E-stage controls plus D-stage ImmSrc/RegSrc and class flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the decoded word is consumed.
module decode_main_dec
  import decode_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int REG_W   = 4
) (
  input  logic [1:0]         op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [REG_W-1:0]   rd,
  output ctrl_s              ctrl,
  output logic [1:0]         imm_src,
  output logic [1:0]         reg_src,
  output logic               is_vec,
  output logic               is_halt
);

  alu_op_e alu_code;
  logic    alu_legal;
  logic    dp_like;
  logic    rd_is_pc;

  assign rd_is_pc = (rd == {REG_W{1'b1}});

  // Map Funct[4:1] onto the fixed ALU code set; anything else is unimplemented.
  always_comb begin
    alu_code  = ALU_ADD;
    alu_legal = 1'b1;
    case (funct[4:1])
      4'b0100: alu_code = ALU_ADD;
      4'b0010: alu_code = ALU_SUB;
      4'b0000: alu_code = ALU_AND;
      4'b1100: alu_code = ALU_ORR;
      4'b0001: alu_code = ALU_MUL;
      4'b0011: alu_code = ALU_AVG;
      4'b0101: alu_code = ALU_THR;
      4'b0111: alu_code = ALU_SHL;
      default: alu_legal = 1'b0;
    endcase
  end

  // Class decode; vector ops reuse the DP path with register operands.
  always_comb begin
    ctrl    = '0;
    imm_src = 2'b00;
    reg_src = 2'b00;
    is_vec  = 1'b0;
    is_halt = 1'b0;
    dp_like = 1'b0;
    case (op)
      OP_DP: begin
        dp_like      = 1'b1;
        ctrl.alu_src = funct[5];
      end
      OP_MEM: begin
        imm_src      = 2'b01;
        ctrl.alu_src = 1'b1;
        if (funct[0]) begin
          ctrl.memto_reg = 1'b1;
          ctrl.reg_write = 1'b1;
        end else begin
          reg_src        = 2'b10;
          ctrl.mem_write = 1'b1;
        end
      end
      OP_BR: begin
        reg_src      = 2'b01;
        imm_src      = 2'b10;
        ctrl.alu_src = 1'b1;
        ctrl.branch  = 1'b1;
      end
      default: begin
        if (funct[5]) begin
          is_vec  = 1'b1;
          dp_like = 1'b1;
        end else begin
          is_halt = 1'b1;
        end
      end
    endcase
    if (dp_like) begin
      if (alu_legal) begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_ctl    = alu_code;
        ctrl.flag_write = {funct[0], funct[0] & writes_cv(alu_code)};
      end else begin
        ctrl.illegal = 1'b1;
      end
    end
    // A vector op may never retarget the PC, so its write to the PC index is dropped.
    if (is_vec && rd_is_pc) ctrl.reg_write = 1'b0;
    ctrl.pc_src = (rd_is_pc & ctrl.reg_write) | ctrl.branch;
  end

endmodule

// File: rtl/decode_control_seq.sv
// Purpose: decode-stage control with D->E register, vector lane sequencer and sticky halt.
// Latency: 1 cycle decode to E outputs; a vector op takes LANES unstalled cycles.
// Backpressure: StallE holds E and the sequencer; FlushE loads a bubble; StallD holds F/D while sequencing or halted.
module decode_control_seq
  import decode_pkg::*;
#(
  parameter int ALUCTL_W = 3,
  parameter int LANES    = 4,
  parameter int FUNCT_W  = 6,
  parameter int REG_W    = 4,
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                InstrValidD,
  input  logic [1:0]          Op,
  input  logic [FUNCT_W-1:0]  Funct,
  input  logic [REG_W-1:0]    Rd,
  input  logic                StallE,
  input  logic                FlushE,
  output logic [1:0]          ImmSrcD,
  output logic [1:0]          RegSrcD,
  output logic                StallD,
  output logic                RegWriteE,
  output logic                MemtoRegE,
  output logic                MemWriteE,
  output logic                BranchE,
  output logic                ALUSrcE,
  output logic                PCSrcE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic [1:0]          FlagWriteE,
  output logic [LW-1:0]       LaneE,
  output logic                VecLastE,
  output logic                IllegalE,
  output logic                Halted
);

  localparam bit            MULTI     = (LANES > 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  ctrl_s      dec_ctrl;
  logic       is_vec;
  logic       is_halt;
  seq_state_e state, next_state;
  logic [LW-1:0] cnt, next_cnt;
  ctrl_s      e_q, e_d;
  logic [LW-1:0] lane_q, lane_d;
  logic       last_q, last_d;
  logic       load_e;

  decode_main_dec #(
    .FUNCT_W (FUNCT_W),
    .REG_W   (REG_W)
  ) u_main_dec (
    .op      (Op),
    .funct   (Funct),
    .rd      (Rd),
    .ctrl    (dec_ctrl),
    .imm_src (ImmSrcD),
    .reg_src (RegSrcD),
    .is_vec  (is_vec),
    .is_halt (is_halt)
  );

  // Sequencer next state, F/D stall and the word to load into E.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    load_e     = 1'b0;
    e_d        = '0;
    lane_d     = '0;
    last_d     = 1'b0;
    StallD     = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (FlushE) begin
          load_e = 1'b1;
        end else begin
          StallD = InstrValidD && is_vec && MULTI;
          if (!StallE) begin
            load_e = 1'b1;
            if (InstrValidD && is_halt) begin
              next_state = SEQ_HALT;
            end else if (InstrValidD && is_vec && MULTI) begin
              e_d            = dec_ctrl;
              e_d.flag_write = 2'b00;
              next_cnt       = LW'(1);
              next_state     = SEQ_VEC;
            end else if (InstrValidD) begin
              e_d    = dec_ctrl;
              last_d = 1'b1;
            end
          end
        end
      end
      SEQ_VEC: begin
        if (FlushE) begin
          load_e     = 1'b1;
          next_cnt   = '0;
          next_state = SEQ_IDLE;
        end else begin
          StallD = (cnt != LAST_LANE);
          if (!StallE) begin
            load_e = 1'b1;
            e_d    = dec_ctrl;
            lane_d = cnt;
            if (cnt == LAST_LANE) begin
              last_d     = 1'b1;
              next_cnt   = '0;
              next_state = SEQ_IDLE;
            end else begin
              e_d.flag_write = 2'b00;
              next_cnt       = cnt + LW'(1);
            end
          end
        end
      end
      SEQ_HALT: begin
        StallD = 1'b1;
      end
      default: begin
        next_state = SEQ_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // State, lane counter and D->E pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= SEQ_IDLE;
      cnt    <= '0;
      e_q    <= '0;
      lane_q <= '0;
      last_q <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (load_e) begin
        e_q    <= e_d;
        lane_q <= lane_d;
        last_q <= last_d;
      end
    end
  end

  assign RegWriteE   = e_q.reg_write;
  assign MemtoRegE   = e_q.memto_reg;
  assign MemWriteE   = e_q.mem_write;
  assign BranchE     = e_q.branch;
  assign ALUSrcE     = e_q.alu_src;
  assign PCSrcE      = e_q.pc_src;
  assign ALUControlE = ALUCTL_W'(e_q.alu_ctl);
  assign FlagWriteE  = e_q.flag_write;
  assign IllegalE    = e_q.illegal;
  assign LaneE       = lane_q;
  assign VecLastE    = last_q;
  assign Halted      = (state == SEQ_HALT);

endmodule
